// File: rtl/cam_pkg.sv
// Shared types and default widths for the camera capture path.
package cam_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned COL_W  = 12;
    localparam int unsigned ROW_W  = 11;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLow,
        StWaitSof,
        StCapture,
        StDone
    } cam_state_e;

    // One tagged pixel as it leaves the capture block.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [COL_W-1:0]  col;
        logic [ROW_W-1:0]  row;
        logic              sof;
    } pix_beat_t;

endpackage

// File: rtl/cam_frame_capture_if.sv
// Tagged pixel stream (valid/ready) from the capture block to the buffer writer.
interface cam_frame_capture_if #(
    parameter int unsigned DATA_W = cam_pkg::DATA_W,
    parameter int unsigned COL_W  = cam_pkg::COL_W,
    parameter int unsigned ROW_W  = cam_pkg::ROW_W
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [COL_W-1:0]  out_col;
    logic [ROW_W-1:0]  out_row;
    logic              out_sof;
    logic              out_eol;

    modport master (
        output out_valid, out_data, out_col, out_row, out_sof, out_eol,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_col, out_row, out_sof, out_eol,
        output out_ready
    );

endinterface

// File: rtl/cam_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush. DEPTH must be a power of 2, >= 2.
module cam_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Zero when empty so the stream fields never show stale or unwritten storage.
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush discards everything including this cycle's ops.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) count_q <= count_q + (PTR_W + 1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (PTR_W + 1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clkin) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/cam_frame_capture.sv
// Captures one whole camera frame on request and streams tagged pixels into clkin domain.
module cam_frame_capture #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COL_W       = 12,
    parameter int unsigned ROW_W       = 11,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                pixclk,
    input  logic                fv,
    input  logic                lv,
    input  logic [DATA_W-1:0]   pix_data,
    input  logic                arm,
    input  logic                abort,
    cam_frame_capture_if.master pix_out,
    output logic                busy,
    output logic                frame_done,
    output logic [ROW_W-1:0]    frame_rows,
    output logic [COL_W-1:0]    frame_cols,
    output logic                err_overflow,
    output logic                err_linelen
);

    import cam_pkg::*;

    localparam int unsigned BEAT_W = DATA_W + COL_W + ROW_W + 1;
    localparam logic [COL_W-1:0] COL_MAX = '1;
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

    logic [SYNC_STAGES-1:0] pclk_sync, fv_sync, lv_sync;
    logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
    logic                   pclk_d, fv_d, lv_d;
    logic                   pclk_s, fv_s, lv_s;

    logic                   pclk_rise_q, fv_rise_q, fv_fall_q, lv_fall_q, fv_q, lv_q;
    logic [DATA_W-1:0]      data_q;

    cam_state_e             state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d, frame_rows_q, frame_rows_d;
    logic [COL_W-1:0]       col_q, col_d, col_next, line_len_q, line_len_d;
    logic [COL_W-1:0]       frame_cols_q, frame_cols_d;
    logic                   first_line_q, first_line_d;
    logic                   err_linelen_q, err_linelen_d, err_overflow_q, err_overflow_d;
    logic                   frame_done_q, frame_done_d;

    logic                   pix_ev, push, pop, flush, fifo_full, fifo_empty;
    logic [BEAT_W-1:0]      push_beat, fifo_out;

    assign pclk_s = pclk_sync[SYNC_STAGES-1];
    assign fv_s   = fv_sync[SYNC_STAGES-1];
    assign lv_s   = lv_sync[SYNC_STAGES-1];

    // Synchronisers plus one delayed copy for edge detection; data chain matches pixclk depth.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            pclk_sync <= '0;
            fv_sync   <= '0;
            lv_sync   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
            pclk_d    <= 1'b0;
            fv_d      <= 1'b0;
            lv_d      <= 1'b0;
        end else begin
            pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], pixclk};
            fv_sync   <= {fv_sync[SYNC_STAGES-2:0], fv};
            lv_sync   <= {lv_sync[SYNC_STAGES-2:0], lv};
            data_sync[0] <= pix_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            pclk_d    <= pclk_s;
            fv_d      <= fv_s;
            lv_d      <= lv_s;
        end
    end

    // Registered edge strobes and levels, keeping data aligned with the pixclk strobe.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            pclk_rise_q <= 1'b0;
            fv_rise_q   <= 1'b0;
            fv_fall_q   <= 1'b0;
            lv_fall_q   <= 1'b0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            pclk_rise_q <= pclk_s & ~pclk_d;
            fv_rise_q   <= fv_s & ~fv_d;
            fv_fall_q   <= ~fv_s & fv_d;
            lv_fall_q   <= ~lv_s & lv_d;
            fv_q        <= fv_s;
            lv_q        <= lv_s;
            data_q      <= data_sync[SYNC_STAGES-1];
        end
    end

    assign pix_ev    = pclk_rise_q & fv_q & lv_q;
    assign pop       = ~fifo_empty & pix_out.out_ready;
    assign push_beat = {data_q, col_q, row_q, (row_q == '0) && (col_q == '0)};

    // State register and capture bookkeeping.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            row_q          <= '0;
            col_q          <= '0;
            line_len_q     <= '0;
            first_line_q   <= 1'b0;
            frame_rows_q   <= '0;
            frame_cols_q   <= '0;
            frame_done_q   <= 1'b0;
            err_linelen_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            line_len_q     <= line_len_d;
            first_line_q   <= first_line_d;
            frame_rows_q   <= frame_rows_d;
            frame_cols_q   <= frame_cols_d;
            frame_done_q   <= frame_done_d;
            err_linelen_q  <= err_linelen_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Next-state, counters, FIFO push/flush and status updates.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        col_next       = col_q;
        line_len_d     = line_len_q;
        first_line_d   = first_line_q;
        frame_rows_d   = frame_rows_q;
        frame_cols_d   = frame_cols_q;
        frame_done_d   = 1'b0;
        err_linelen_d  = err_linelen_q;
        err_overflow_d = err_overflow_q;
        push           = 1'b0;
        flush          = 1'b0;

        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        state_d        = StWaitLow;
                        err_linelen_d  = 1'b0;
                        err_overflow_d = 1'b0;
                    end
                end
                // Arming mid-frame lands here, so the current frame is skipped.
                StWaitLow: begin
                    if (!fv_q) state_d = StWaitSof;
                end
                StWaitSof: begin
                    if (fv_rise_q) begin
                        state_d      = StCapture;
                        row_d        = '0;
                        col_d        = '0;
                        line_len_d   = '0;
                        first_line_d = 1'b1;
                    end
                end
                StCapture: begin
                    if (pix_ev) begin
                        push = 1'b1;
                        if (col_q == COL_MAX) err_linelen_d = 1'b1;
                        else col_next = col_q + COL_W'(1);
                    end
                    // Line close sees the pixel pushed this cycle; a partial line at fv_fall counts.
                    if ((lv_fall_q || fv_fall_q) && col_next != '0) begin
                        if (first_line_q) line_len_d = col_next;
                        else if (col_next != line_len_q) err_linelen_d = 1'b1;
                        if (row_q != ROW_MAX) row_d = row_q + ROW_W'(1);
                        col_next     = '0;
                        first_line_d = 1'b0;
                    end
                    col_d = col_next;
                    if (fv_fall_q) state_d = StDone;
                end
                StDone: begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                    frame_rows_d = row_q;
                    frame_cols_d = line_len_q;
                end
                default: state_d = StIdle;
            endcase
        end

        if (push && fifo_full && !pop) err_overflow_d = 1'b1;
    end

    cam_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkin     (clkin),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_beat),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty)
    );

    assign pix_out.out_valid = ~fifo_empty;
    assign pix_out.out_sof   = fifo_out[0];
    assign pix_out.out_row   = fifo_out[ROW_W:1];
    assign pix_out.out_col   = fifo_out[COL_W+ROW_W:ROW_W+1];
    assign pix_out.out_data  = fifo_out[BEAT_W-1:COL_W+ROW_W+1];
    assign pix_out.out_eol   = 1'b0;

    assign busy         = (state_q != StIdle);
    assign frame_done   = frame_done_q;
    assign frame_rows   = frame_rows_q;
    assign frame_cols   = frame_cols_q;
    assign err_overflow = err_overflow_q;
    assign err_linelen  = err_linelen_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: drives camera frames on an emulated pixclk, scores the stream.
module tb_cam_frame_capture;

    import cam_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;

    logic              clkin = 1'b0;
    logic              reset = 1'b1;
    logic              pixclk = 1'b0;
    logic              fv = 1'b0;
    logic              lv = 1'b0;
    logic [DATA_W-1:0] pix_data = '0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              busy, frame_done, err_overflow, err_linelen;
    logic [ROW_W-1:0]  frame_rows;
    logic [COL_W-1:0]  frame_cols;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    bit throttle = 1'b0;

    pix_beat_t         got[$];
    pix_beat_t         exp_q[$];
    int                lens[$];
    logic [DATA_W-1:0] pix[$];

    always #10 clkin = ~clkin;

    cam_frame_capture_if #(.DATA_W(DATA_W), .COL_W(COL_W), .ROW_W(ROW_W)) pix_out_if ();

    cam_frame_capture #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .COL_W       (COL_W),
        .ROW_W       (ROW_W),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .pixclk       (pixclk),
        .fv           (fv),
        .lv           (lv),
        .pix_data     (pix_data),
        .arm          (arm),
        .abort        (abort),
        .pix_out      (pix_out_if),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_rows   (frame_rows),
        .frame_cols   (frame_cols),
        .err_overflow (err_overflow),
        .err_linelen  (err_linelen)
    );

    // Collect accepted beats and frame_done pulses away from the active edge.
    always @(negedge clkin) begin
        pix_beat_t b;
        if (pix_out_if.out_valid && pix_out_if.out_ready) begin
            b.data = pix_out_if.out_data;
            b.col  = pix_out_if.out_col;
            b.row  = pix_out_if.out_row;
            b.sof  = pix_out_if.out_sof;
            got.push_back(b);
        end
        if (frame_done) done_cnt++;
    end

    // Random backpressure while enabled.
    always @(posedge clkin) begin
        if (throttle) begin
            #2;
            pix_out_if.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got time %0t want earlier finish", $time);
        $fatal(1);
    end

    task automatic tick();
        #83 pixclk = 1'b1;
        #83 pixclk = 1'b0;
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clkin);
        #2;
    endtask

    task automatic pulse_arm();
        @(posedge clkin); #2 arm = 1'b1;
        @(posedge clkin); #2 arm = 1'b0;
    endtask

    task automatic make_frame(input int rows, input int cols);
        lens.delete();
        pix.delete();
        for (int r = 0; r < rows; r++) lens.push_back(cols);
        for (int i = 0; i < rows * cols; i++) pix.push_back(DATA_W'($urandom));
    endtask

    // Reference: every pixel of every line, in raster order, tagged with its position.
    task automatic build_model();
        pix_beat_t b;
        int k = 0;
        exp_q.delete();
        for (int r = 0; r < lens.size(); r++) begin
            for (int c = 0; c < lens[r]; c++) begin
                b.data = pix[k];
                b.col  = COL_W'(c);
                b.row  = ROW_W'(r);
                b.sof  = (r == 0) && (c == 0);
                exp_q.push_back(b);
                k++;
            end
        end
    endtask

    function automatic bit model_lenerr();
        for (int r = 1; r < lens.size(); r++) if (lens[r] != lens[0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic send_frame();
        int k = 0;
        repeat (3) tick();
        fv = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < lens.size(); r++) begin
            lv = 1'b1;
            for (int c = 0; c < lens[r]; c++) begin
                pix_data = pix[k];
                k++;
                tick();
            end
            lv = 1'b0;
            pix_data = DATA_W'($urandom);
            repeat (2) tick();
        end
        fv = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        #25;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (frame_done !== 1'b0) $display("FAIL rst_done: got %b want 0", frame_done); else passes++;
        checks++; if (pix_out_if.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", pix_out_if.out_valid); else passes++;
        #30 reset = 1'b0;
        @(negedge clkin);
        checks++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy); else passes++;
        checks++; if (frame_rows !== '0) $display("FAIL rst_rows: got %0d want 0", frame_rows); else passes++;
        checks++; if (frame_cols !== '0) $display("FAIL rst_cols: got %0d want 0", frame_cols); else passes++;
        checks++; if (err_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", err_overflow); else passes++;
        checks++; if (err_linelen !== 1'b0) $display("FAIL rst_linelen: got %b want 0", err_linelen); else passes++;
        checks++; if (pix_out_if.out_valid !== 1'b0) $display("FAIL rst_fifo_empty: got %b want 0", pix_out_if.out_valid); else passes++;
        checks++; if (pix_out_if.out_data !== '0 || pix_out_if.out_col !== '0 || pix_out_if.out_row !== '0)
            $display("FAIL rst_stream: got %h/%0d/%0d want 0/0/0", pix_out_if.out_data, pix_out_if.out_col, pix_out_if.out_row); else passes++;
        checks++; if (pix_out_if.out_sof !== 1'b0 || pix_out_if.out_eol !== 1'b0)
            $display("FAIL rst_sof_eol: got %b%b want 00", pix_out_if.out_sof, pix_out_if.out_eol); else passes++;
    endtask

    task automatic test_basic_frame();
        pix_beat_t gb;
        got.delete(); done_cnt = 0;
        pulse_arm();
        make_frame(3, 4);
        build_model();
        send_frame();
        clk_wait(20);
        checks++; if (got.size() != 12) $display("FAIL basic_count: got %0d want 12", got.size()); else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got.size()) ? got[i] : '0;
            checks++; if (gb !== exp_q[i]) $display("FAIL basic_beat%0d: got %h want %h", i, gb, exp_q[i]); else passes++;
        end
        checks++; if (done_cnt != 1) $display("FAIL basic_done: got %0d want 1", done_cnt); else passes++;
        checks++; if (frame_rows !== 3) $display("FAIL basic_rows: got %0d want 3", frame_rows); else passes++;
        checks++; if (frame_cols !== 4) $display("FAIL basic_cols: got %0d want 4", frame_cols); else passes++;
        checks++; if (err_overflow !== 1'b0 || err_linelen !== 1'b0)
            $display("FAIL basic_err: got %b%b want 00", err_overflow, err_linelen); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", busy); else passes++;
    endtask

    task automatic test_midframe_arm();
        pix_beat_t gb;
        got.delete(); done_cnt = 0;
        make_frame(3, 4);
        fork
            send_frame();
            begin #1500; pulse_arm(); end
        join
        make_frame(3, 4);
        build_model();
        send_frame();
        clk_wait(20);
        checks++; if (got.size() != exp_q.size()) $display("FAIL mid_count: got %0d want %0d", got.size(), exp_q.size()); else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got.size()) ? got[i] : '0;
            checks++; if (gb !== exp_q[i]) $display("FAIL mid_beat%0d: got %h want %h", i, gb, exp_q[i]); else passes++;
        end
        checks++; if (done_cnt != 1) $display("FAIL mid_done: got %0d want 1", done_cnt); else passes++;
        checks++; if (frame_rows !== 3) $display("FAIL mid_rows: got %0d want 3", frame_rows); else passes++;
    endtask

    task automatic test_overflow();
        pix_beat_t gb;
        got.delete(); done_cnt = 0;
        pix_out_if.out_ready = 1'b0;
        pulse_arm();
        make_frame(3, 4);
        build_model();
        send_frame();
        clk_wait(20);
        checks++; if (got.size() != 0) $display("FAIL ovf_held: got %0d beats want 0", got.size()); else passes++;
        checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", err_overflow); else passes++;
        checks++; if (err_linelen !== 1'b0) $display("FAIL ovf_linelen: got %b want 0", err_linelen); else passes++;
        checks++; if (done_cnt != 1) $display("FAIL ovf_done: got %0d want 1", done_cnt); else passes++;
        checks++; if (frame_rows !== 3 || frame_cols !== 4)
            $display("FAIL ovf_size: got %0dx%0d want 3x4", frame_rows, frame_cols); else passes++;
        pix_out_if.out_ready = 1'b1;
        clk_wait(10);
        checks++; if (got.size() != FIFO_DEPTH) $display("FAIL ovf_count: got %0d want %0d", got.size(), FIFO_DEPTH); else passes++;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            gb = (i < got.size()) ? got[i] : '0;
            checks++; if (gb !== exp_q[i]) $display("FAIL ovf_beat%0d: got %h want %h", i, gb, exp_q[i]); else passes++;
        end
    endtask

    task automatic test_linelen();
        pix_beat_t gb;
        got.delete(); done_cnt = 0;
        pulse_arm();
        clk_wait(1);
        checks++; if (err_overflow !== 1'b0) $display("FAIL arm_clears_ovf: got %b want 0", err_overflow); else passes++;
        make_frame(3, 4);
        lens[2] = 3;
        void'(pix.pop_back());
        build_model();
        send_frame();
        clk_wait(20);
        checks++; if (got.size() != 11) $display("FAIL len_count: got %0d want 11", got.size()); else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got.size()) ? got[i] : '0;
            checks++; if (gb !== exp_q[i]) $display("FAIL len_beat%0d: got %h want %h", i, gb, exp_q[i]); else passes++;
        end
        checks++; if (err_linelen !== 1'b1) $display("FAIL len_flag: got %b want 1", err_linelen); else passes++;
        checks++; if (frame_cols !== 4) $display("FAIL len_cols: got %0d want 4", frame_cols); else passes++;
        checks++; if (frame_rows !== 3) $display("FAIL len_rows: got %0d want 3", frame_rows); else passes++;
        checks++; if (done_cnt != 1) $display("FAIL len_done: got %0d want 1", done_cnt); else passes++;
    endtask

    task automatic test_abort();
        pix_beat_t gb;
        got.delete(); done_cnt = 0;
        pulse_arm();
        make_frame(3, 4);
        fork
            send_frame();
            begin
                int w = 0;
                while (got.size() < 5 && w < 3000) begin @(negedge clkin); w++; end
                checks++; if (got.size() < 5) $display("FAIL abort_wait: got %0d beats want 5", got.size()); else passes++;
                @(posedge clkin); #2 abort = 1'b1;
                @(posedge clkin); #2 abort = 1'b0;
                checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passes++;
                checks++; if (pix_out_if.out_valid !== 1'b0) $display("FAIL abort_flush: got %b want 0", pix_out_if.out_valid); else passes++;
            end
        join
        clk_wait(10);
        checks++; if (got.size() != 5) $display("FAIL abort_count: got %0d want 5", got.size()); else passes++;
        checks++; if (done_cnt != 0) $display("FAIL abort_done: got %0d want 0", done_cnt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", busy); else passes++;
        got.delete();
        pulse_arm();
        make_frame(2, 5);
        build_model();
        send_frame();
        clk_wait(20);
        checks++; if (got.size() != exp_q.size()) $display("FAIL reab_count: got %0d want %0d", got.size(), exp_q.size()); else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got.size()) ? got[i] : '0;
            checks++; if (gb !== exp_q[i]) $display("FAIL reab_beat%0d: got %h want %h", i, gb, exp_q[i]); else passes++;
        end
        checks++; if (done_cnt != 1) $display("FAIL reab_done: got %0d want 1", done_cnt); else passes++;
        checks++; if (frame_rows !== 2 || frame_cols !== 5)
            $display("FAIL reab_size: got %0dx%0d want 2x5", frame_rows, frame_cols); else passes++;
    endtask

    task automatic test_reset_midframe();
        int n_before = 0;
        got.delete(); done_cnt = 0;
        pulse_arm();
        make_frame(3, 4);
        fork
            send_frame();
            begin
                int w = 0;
                while (got.size() < 3 && w < 3000) begin @(negedge clkin); w++; end
                checks++; if (got.size() < 3) $display("FAIL rstm_wait: got %0d beats want 3", got.size()); else passes++;
                @(negedge clkin); #3 reset = 1'b1;
                #4;
                checks++; if (busy !== 1'b0 || frame_done !== 1'b0)
                    $display("FAIL rstm_busy: got %b%b want 00", busy, frame_done); else passes++;
                checks++; if (pix_out_if.out_valid !== 1'b0) $display("FAIL rstm_fifo: got %b want 0", pix_out_if.out_valid); else passes++;
                checks++; if (frame_rows !== '0 || frame_cols !== '0)
                    $display("FAIL rstm_size: got %0dx%0d want 0x0", frame_rows, frame_cols); else passes++;
                checks++; if (err_overflow !== 1'b0 || err_linelen !== 1'b0)
                    $display("FAIL rstm_err: got %b%b want 00", err_overflow, err_linelen); else passes++;
                n_before = got.size();
                repeat (3) @(posedge clkin);
                #3 reset = 1'b0;
            end
        join
        clk_wait(10);
        checks++; if (got.size() != n_before) $display("FAIL rstm_after: got %0d want %0d", got.size(), n_before); else passes++;
        checks++; if (done_cnt != 0) $display("FAIL rstm_done: got %0d want 0", done_cnt); else passes++;
        make_frame(3, 4);
        send_frame();
        clk_wait(10);
        checks++; if (got.size() != n_before) $display("FAIL rstm_noarm: got %0d want %0d", got.size(), n_before); else passes++;
        checks++; if (busy !== 1'b0 || done_cnt != 0)
            $display("FAIL rstm_noarm_state: got busy %b done %0d want 0 0", busy, done_cnt); else passes++;
    endtask

    task automatic test_back_to_back();
        pix_beat_t gb;
        for (int f = 0; f < 3; f++) begin
            got.delete(); done_cnt = 0;
            pulse_arm();
            make_frame($urandom_range(1, 5), $urandom_range(1, 8));
            build_model();
            throttle = 1'b1;
            send_frame();
            throttle = 1'b0;
            clk_wait(1);
            pix_out_if.out_ready = 1'b1;
            clk_wait(20);
            checks++; if (got.size() != exp_q.size())
                $display("FAIL b2b%0d_count: got %0d want %0d", f, got.size(), exp_q.size()); else passes++;
            for (int i = 0; i < exp_q.size(); i++) begin
                gb = (i < got.size()) ? got[i] : '0;
                checks++; if (gb !== exp_q[i]) $display("FAIL b2b%0d_beat%0d: got %h want %h", f, i, gb, exp_q[i]); else passes++;
            end
            checks++; if (done_cnt != 1) $display("FAIL b2b%0d_done: got %0d want 1", f, done_cnt); else passes++;
            checks++; if (frame_rows !== ROW_W'(lens.size()) || frame_cols !== COL_W'(lens[0]))
                $display("FAIL b2b%0d_size: got %0dx%0d want %0dx%0d", f, frame_rows, frame_cols, lens.size(), lens[0]);
            else passes++;
            checks++; if (err_linelen !== model_lenerr() || err_overflow !== 1'b0)
                $display("FAIL b2b%0d_err: got %b%b want %b0", f, err_linelen, err_overflow, model_lenerr()); else passes++;
        end
    endtask

    initial begin
        pix_out_if.out_ready = 1'b1;
        test_reset();
        test_basic_frame();
        test_midframe_arm();
        test_overflow();
        test_linelen();
        test_abort();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cam_frame_capture.md
Name: cam_frame_capture

Overview:
- Consumes the camera-side pixclk/fv/lv/data stream (real sensor or internal emulated pixel clock) and brings it into the 50 MHz clkin domain.
- On software arm, captures exactly one whole frame.
- Emits pixels with row/col tags over a valid/ready stream to the image buffer writer, through a small FIFO.
- Reports frame completion, size and errors.

Parameters:
- DATA_W, 8, pixel data width.
- SYNC_STAGES, 2, synchroniser depth for pixclk/fv/lv/data; legal range 2..3.
- COL_W, 12, column counter width (max 4095 columns).
- ROW_W, 11, row counter width (max 2047 rows).
- FIFO_DEPTH, 4, output FIFO entries; power of 2.

Ports:
- clkin, input, 1, 50 MHz system clock.
- reset, input, 1, asynchronous, active-high.
- pixclk, input, 1, camera pixel clock, ≤12.5 MHz, asynchronous to clkin.
- fv, input, 1, frame valid, asynchronous.
- lv, input, 1, line valid, asynchronous.
- pix_data, input, DATA_W, pixel data, stable around the pixclk rising edge.
- arm, input, 1, one-cycle pulse; request capture of the next full frame.
- abort, input, 1, one-cycle pulse; abandon the capture in progress.
- out_valid, output, 1, pixel available.
- out_ready, input, 1, downstream accepts pixel.
- out_data, output, DATA_W, pixel value.
- out_col, output, COL_W, column index of pixel within its line.
- out_row, output, ROW_W, row index of pixel.
- out_sof, output, 1, marks first pixel of frame.
- out_eol, output, 1, reserved; tied 0.
- busy, output, 1, high in any state except IDLE.
- frame_done, output, 1, one-cycle pulse at frame end.
- frame_rows, output, ROW_W, lines in last frame; held until next frame_done.
- frame_cols, output, COL_W, length of first line of last frame; held until next frame_done.
- err_overflow, output, 1, sticky; pixel dropped because FIFO full. Cleared by arm.
- err_linelen, output, 1, sticky; a line length differed from the first line. Cleared by arm.

Behaviour:
- Reset value of every output is 0; FIFO is empty after reset.
- Synchronisation:
  - pixclk, fv, lv and pix_data each pass through a SYNC_STAGES flop chain on clkin.
  - Delayed copies give the edges pclk_rise, fv_rise, fv_fall, lv_fall (single-cycle strobes).
  - The data chain matches the pixclk chain depth, so the sample at pclk_rise is the data present at the pixclk edge.
- Pixel event: pclk_rise AND fv_s AND lv_s, taken only in state CAPTURE.
- State machine:
  - IDLE: arm → WAIT_LOW.
  - WAIT_LOW: fv_s==0 → WAIT_SOF. Arming mid-frame therefore skips the current frame.
  - WAIT_SOF: fv_rise → CAPTURE. On entry, row=0, col=0, first_line=1.
  - CAPTURE, each pixel event:
    - Push {data, col, row, sof} into the FIFO; col++.
    - sof=1 only for row 0, col 0.
  - CAPTURE, lv_fall with col≠0:
    - If first_line, latch line_len=col.
    - Else, if col≠line_len, set err_linelen.
    - Then row++, col=0, first_line=0.
  - CAPTURE, fv_fall → DONE. A partial line (col≠0) counts as a row and is length-checked as above.
  - DONE: frame_rows=row, frame_cols=line_len, frame_done pulse for 1 cycle → IDLE.
- abort in any state except IDLE → IDLE next cycle:
  - No frame_done is generated.
  - The FIFO is flushed in that same cycle.
- Simultaneous events:
  - arm while busy: ignored.
  - abort and arm in the same cycle: abort wins.
  - Pixel event and lv_fall in the same cycle: the pixel is pushed first, then the line close uses col+1.
- Counter limits:
  - col saturates at 2^COL_W−1 and sets err_linelen.
  - row saturates at 2^ROW_W−1.
  - Neither wraps.
- FIFO:
  - Synchronous, single clkin domain, show-ahead.
  - out_valid = not empty; a pop happens on out_valid & out_ready.
  - Push to a full FIFO: pixel discarded, err_overflow set.
  - Simultaneous push and pop when full: allowed; no overflow.
- Latency: pixel at the pins to out_valid is SYNC_STAGES+2 clkin cycles, with an empty FIFO and out_ready=1.
- Throughput: one pixel per pixclk period; needs pixclk ≤ clkin/4.
- Reset mid-frame: everything cleared, state IDLE. The next capture requires a new arm.

Decomposition:
- Shared package cam_pkg holds:
  - state enum.
  - pixel-beat struct {data, col, row, sof}.
  - default widths (DATA_W, COL_W, ROW_W).
- Natural sub-module: cam_sync_fifo (parameterised width/depth, with flush input). Reused by other image-path stages.

Test Plan:
- 4-col × 3-row frame (each line lv high 4 pclks), pixclk 6 MHz, arm before fv, out_ready=1:
  - 12 beats, data in order, (row,col) from (0,0) to (2,3).
  - out_sof only on the first beat.
  - frame_done once; frame_rows=3, frame_cols=4; no errors.
- arm asserted mid-frame: remainder of current frame produces no beats; next full frame captured; frame_rows=3.
- out_ready=0 through a 12-pixel frame, FIFO_DEPTH=4: exactly 4 beats retained, err_overflow=1. After out_ready=1, the 4 beats are (0,0)..(0,3).
- Line lengths 4, 4, 3: err_linelen=1, frame_cols=4, frame_rows=3.
- abort after 5 pixels: busy=0 next cycle, FIFO empty, no frame_done; a later arm captures a clean frame.
- Async reset during CAPTURE: all outputs 0 within the reset assertion; FIFO empty; further fv/lv activity ignored until arm.
